// File: rtl/vga_box_renderer_if.sv
// ============================================================================
// vga_box_renderer_if : timing-generator inputs and pixel outputs of the renderer
// Revision 1.0
// ============================================================================
`default_nettype none

interface vga_box_renderer_if;
  logic       enable;
  logic [9:0] x_count;
  logic [9:0] y_count;
  logic       hsync_in;
  logic       vsync_in;
  logic       active_in;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync_out;
  logic       vsync_out;
  logic [9:0] box_x;
  logic [9:0] box_y;

  modport master (
    output enable, x_count, y_count, hsync_in, vsync_in, active_in,
    input  vga_r, vga_g, vga_b, hsync_out, vsync_out, box_x, box_y
  );

  modport slave (
    input  enable, x_count, y_count, hsync_in, vsync_in, active_in,
    output vga_r, vga_g, vga_b, hsync_out, vsync_out, box_x, box_y
  );
endinterface

`default_nettype wire

// File: rtl/vga_box_renderer.sv
// ============================================================================
// vga_box_renderer : bouncing square pixel stage; optional white frame via BORDER_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_box_renderer #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic                clk_25,
  input  logic                rst,
  vga_box_renderer_if.slave   bus
);

  localparam logic [10:0] c_step  = 11'(STEP);
  localparam logic [10:0] c_size  = 11'(BOX_SIZE);
  localparam logic [10:0] c_x_max = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_y_max = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  c_x_last = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  c_y_last = 10'(V_ACTIVE - 1);

  // bit 0 set = moving left, bit 1 set = moving up
  typedef enum logic [1:0] {
    DR = 2'b00,
    DL = 2'b01,
    UR = 2'b10,
    UL = 2'b11
  } dir_t;

  dir_t        r_state;
  dir_t        w_next_state;
  logic [9:0]  r_box_x;
  logic [9:0]  r_box_y;
  logic [9:0]  w_next_x;
  logic [9:0]  w_next_y;
  logic [11:0] r_rgb;
  logic [11:0] w_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        w_tick;
  logic        w_inside;
  logic        w_x_neg;
  logic        w_y_neg;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic [10:0] w_bx11;
  logic [10:0] w_by11;

  assign w_x11  = {1'b0, bus.x_count};
  assign w_y11  = {1'b0, bus.y_count};
  assign w_bx11 = {1'b0, r_box_x};
  assign w_by11 = {1'b0, r_box_y};

  assign w_tick = (bus.x_count == c_x_last) && (bus.y_count == c_y_last);

  assign w_inside = (w_x11 >= w_bx11) && (w_x11 < w_bx11 + c_size) &&
                    (w_y11 >= w_by11) && (w_y11 < w_by11 + c_size);

`ifdef BORDER_EN
  logic w_border;
  assign w_border = (bus.x_count == 10'd0) || (bus.x_count == c_x_last) ||
                    (bus.y_count == 10'd0) || (bus.y_count == c_y_last);
`endif

  always_comb begin
    w_rgb = 12'h000;
    if (bus.active_in) begin
`ifdef BORDER_EN
      if (w_border)      w_rgb = 12'hFFF;
      else if (w_inside) w_rgb = BOX_COLOR;
      else               w_rgb = BG_COLOR;
`else
      if (w_inside) w_rgb = BOX_COLOR;
      else          w_rgb = BG_COLOR;
`endif
    end
  end

  // Each axis bounces independently; a corner hit flips both on one tick
  always_comb begin
    w_next_x     = r_box_x;
    w_next_y     = r_box_y;
    w_next_state = r_state;
    w_x_neg      = r_state[0];
    w_y_neg      = r_state[1];
    if (w_tick && bus.enable) begin
      if (!r_state[0]) begin
        if (w_bx11 + c_step >= c_x_max) begin
          w_next_x = c_x_max[9:0];
          w_x_neg  = 1'b1;
        end else begin
          w_next_x = r_box_x + c_step[9:0];
        end
      end else begin
        if (w_bx11 <= c_step) begin
          w_next_x = 10'd0;
          w_x_neg  = 1'b0;
        end else begin
          w_next_x = r_box_x - c_step[9:0];
        end
      end

      if (!r_state[1]) begin
        if (w_by11 + c_step >= c_y_max) begin
          w_next_y = c_y_max[9:0];
          w_y_neg  = 1'b1;
        end else begin
          w_next_y = r_box_y + c_step[9:0];
        end
      end else begin
        if (w_by11 <= c_step) begin
          w_next_y = 10'd0;
          w_y_neg  = 1'b0;
        end else begin
          w_next_y = r_box_y - c_step[9:0];
        end
      end

      w_next_state = dir_t'({w_y_neg, w_x_neg});
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst) begin
      r_state <= DR;
      r_box_x <= 10'd0;
      r_box_y <= 10'd0;
      r_rgb   <= 12'h000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_box_x <= w_next_x;
      r_box_y <= w_next_y;
      r_rgb   <= w_rgb;
      r_hsync <= bus.hsync_in;
      r_vsync <= bus.vsync_in;
    end
  end

  assign bus.vga_r     = r_rgb[11:8];
  assign bus.vga_g     = r_rgb[7:4];
  assign bus.vga_b     = r_rgb[3:0];
  assign bus.hsync_out = r_hsync;
  assign bus.vsync_out = r_vsync;
  assign bus.box_x     = r_box_x;
  assign bus.box_y     = r_box_y;

endmodule

`default_nettype wire

// File: tb/tb_vga_box_renderer.sv
// ============================================================================
// tb_vga_box_renderer : directed checks of rendering, sync delay and bounce path
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_box_renderer;

  logic clk_25 = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  vga_box_renderer_if bus();

  vga_box_renderer dut (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (bus)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_25);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic act);
    bus.x_count   = 10'(x);
    bus.y_count   = 10'(y);
    bus.active_in = act;
    cycle();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) pixel(639, 479, 1'b1);
  endtask

  task automatic check_box(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(bus.box_x), 32'(ex));
    check({tag, "_y"}, 32'(bus.box_y), 32'(ey));
  endtask

  initial begin
    rst           = 1'b0;
    bus.enable    = 1'b1;
    bus.x_count   = 10'd0;
    bus.y_count   = 10'd0;
    bus.active_in = 1'b0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;

    repeat (10) cycle();
    check("rst_hsync", 32'(bus.hsync_out), 32'd1);
    check("rst_vsync", 32'(bus.vsync_out), 32'd1);
    check("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
    check_box("rst_box", 0, 0);

    rst          = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;

    // first tick renders last pixel with the old (0,0) box, then moves
    run_ticks(1);
    check("tick_pix", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
    check_box("tick1", 2, 2);

    bus.enable = 1'b0;
    run_ticks(3);
    check_box("freeze", 2, 2);
    bus.enable = 1'b1;

    pixel(5, 5, 1'b1);
    check("in_box", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hF00);
    pixel(34, 5, 1'b1);
    check("right_out", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
    pixel(33, 5, 1'b1);
    check("right_in", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hF00);
    pixel(1, 5, 1'b1);
    check("left_out", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
    pixel(5, 34, 1'b1);
    check("bottom_out", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
    pixel(5, 5, 1'b0);
    check("blank", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
`ifdef BORDER_EN
    pixel(0, 100, 1'b1);
    check("border", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFF);
`else
    pixel(0, 100, 1'b1);
    check("no_border", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
`endif

    bus.hsync_in = 1'b0;
    pixel(100, 100, 1'b0);
    check("hs_delay0", 32'(bus.hsync_out), 32'd0);
    check("vs_delay1", 32'(bus.vsync_out), 32'd1);
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b0;
    pixel(100, 100, 1'b0);
    check("hs_delay1", 32'(bus.hsync_out), 32'd1);
    check("vs_delay0", 32'(bus.vsync_out), 32'd0);
    bus.vsync_in = 1'b1;

    // 1 enabled tick so far; bottom bounce at tick 224
    run_ticks(223);
    check_box("bottom_hit", 448, 448);
    run_ticks(1);
    check_box("bottom_after", 450, 446);
    run_ticks(78);
    check_box("t303", 606, 290);
    run_ticks(1);
    check_box("right_hit", 608, 288);
    run_ticks(1);
    check_box("right_after", 606, 286);

    // x returns to 0 while y reaches 448 at tick 4256: DL -> UR corner
    run_ticks(3950);
    check_box("t4255", 2, 446);
    run_ticks(1);
    check_box("corner", 0, 448);
    pixel(5, 479, 1'b1);
    check("corner_pix", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hF00);
    run_ticks(1);
    check_box("corner_after", 2, 446);

    bus.hsync_in = 1'b0;
    pixel(300, 200, 1'b1);
    rst = 1'b0;
    pixel(300, 200, 1'b1);
    check("midrst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
    check("midrst_hs", 32'(bus.hsync_out), 32'd1);
    check_box("midrst", 0, 0);
    rst          = 1'b1;
    bus.hsync_in = 1'b1;
    run_ticks(1);
    check_box("post_rst", 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
